// File: rtl/pc_fetch_seq_pkg.sv
`default_nettype none
// ============================================================================
// pc_fetch_seq_pkg : shared encodings for the MSP430 PC / fetch sequencer
// Rev 1.0
// ============================================================================
package pc_fetch_seq_pkg;

    localparam logic [15:0] RESET_VECTOR_DEF = 16'hFFFE;

    localparam logic [2:0] ST_BOOT    = 3'd0;
    localparam logic [2:0] ST_RST_VEC = 3'd1;
    localparam logic [2:0] ST_FETCH   = 3'd2;
    localparam logic [2:0] ST_DECODE  = 3'd3;
    localparam logic [2:0] ST_EXT     = 3'd4;
    localparam logic [2:0] ST_EXEC    = 3'd5;

    localparam logic [2:0] MPC_HOLD    = 3'd0;
    localparam logic [2:0] MPC_INC     = 3'd1;
    localparam logic [2:0] MPC_CALC    = 3'd2;
    localparam logic [2:0] MPC_MDB_SHL = 3'd3;
    localparam logic [2:0] MPC_MDB     = 3'd4;

    localparam logic [1:0] SRC_HOLD    = 2'd0;
    localparam logic [1:0] SRC_CALC    = 2'd1;
    localparam logic [1:0] SRC_MDB     = 2'd2;
    localparam logic [1:0] SRC_MDB_SHL = 2'd3;

    // Translate the execute unit's PC-update request into a mux select.
    function automatic logic [2:0] mpc_for_src(input logic [1:0] src);
        logic [2:0] sel;
        case (src)
            SRC_CALC:    sel = MPC_CALC;
            SRC_MDB:     sel = MPC_MDB;
            SRC_MDB_SHL: sel = MPC_MDB_SHL;
            default:     sel = MPC_HOLD;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_seq.sv
`default_nettype none
// ============================================================================
// pc_fetch_seq : PC register and fetch sequencer (vector, fetch, ext, update)
// Rev 1.0
// ============================================================================
module pc_fetch_seq
    import pc_fetch_seq_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int          MAX_EXT      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] MDB,
    input  logic        mem_rdy,
    input  logic [15:0] reg_PC_in,
    input  logic        dec_valid,
    input  logic [1:0]  dec_ext_cnt,
    input  logic        exec_done,
    input  logic [1:0]  exec_pc_src,
    output logic [2:0]  MPC,
    output logic [15:0] reg_PC_out,
    output logic [15:0] MAB,
    output logic        mem_rd,
    output logic [15:0] IR,
    output logic        ir_valid,
    output logic [15:0] ext0,
    output logic [15:0] ext1
);

    localparam logic [1:0] MAX_EXT_C = 2'(MAX_EXT);

    logic [2:0]  state_q,    state_d;
    logic [15:0] pc_q,       pc_d;
    logic [15:0] ir_q,       ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic [15:0] ext0_q,     ext0_d;
    logic [15:0] ext1_q,     ext1_d;
    logic [1:0]  cnt_q,      cnt_d;
    logic        idx_q,      idx_d;

    // The PC reloads every cycle; holding is simply the mux selecting the PC.
    assign pc_d = reg_PC_in & 16'hFFFE;

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        ext0_d     = ext0_q;
        ext1_d     = ext1_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        MPC        = MPC_HOLD;
        MAB        = 16'h0000;
        mem_rd     = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RST_VEC;
            end
            ST_RST_VEC: begin
                mem_rd = 1'b1;
                MAB    = RESET_VECTOR;
                if (mem_rdy) begin
                    MPC     = MPC_MDB;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_rd = 1'b1;
                MAB    = pc_q;
                if (mem_rdy) begin
                    ir_d       = MDB;
                    ir_valid_d = 1'b1;
                    MPC        = MPC_INC;
                    state_d    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_valid) begin
                    ir_valid_d = 1'b0;
                    idx_d      = 1'b0;
                    cnt_d      = (dec_ext_cnt > MAX_EXT_C) ? MAX_EXT_C : dec_ext_cnt;
                    state_d    = (dec_ext_cnt == 2'd0) ? ST_EXEC : ST_EXT;
                end
            end
            ST_EXT: begin
                mem_rd = 1'b1;
                MAB    = pc_q;
                if (mem_rdy) begin
                    if (idx_q) ext1_d = MDB;
                    else       ext0_d = MDB;
                    idx_d = 1'b1;
                    MPC   = MPC_INC;
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    MPC     = mpc_for_src(exec_pc_src);
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= 16'h0000;
            ir_q       <= 16'h0000;
            ir_valid_q <= 1'b0;
            ext0_q     <= 16'h0000;
            ext1_q     <= 16'h0000;
            cnt_q      <= 2'd0;
            idx_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            ext0_q     <= ext0_d;
            ext1_q     <= ext1_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
        end
    end

    assign reg_PC_out = pc_q;
    assign IR         = ir_q;
    assign ir_valid   = ir_valid_q;
    assign ext0       = ext0_q;
    assign ext1       = ext1_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_seq.sv
`default_nettype none
// ============================================================================
// tb_pc_fetch_seq : directed bench with a transaction-level PC/fetch model
// Rev 1.0
// ============================================================================
module tb_pc_fetch_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] MDB = 16'h0000;
    logic        mem_rdy = 1'b0;
    logic        dec_valid = 1'b0;
    logic [1:0]  dec_ext_cnt = 2'd0;
    logic        exec_done = 1'b0;
    logic [1:0]  exec_pc_src = 2'd0;
    logic [15:0] calc_out = 16'h0000;

    logic [15:0] reg_PC_in;
    logic [2:0]  MPC;
    logic [15:0] reg_PC_out, MAB, IR, ext0, ext1;
    logic        mem_rd, ir_valid;

    // Model state and per-cycle expectations
    logic [15:0] m_pc = 16'h0, m_ir = 16'h0, m_ext0 = 16'h0, m_ext1 = 16'h0;
    logic        m_irv = 1'b0;
    logic        exp_rd = 1'b0, exp_mab_vld = 1'b0;
    logic [15:0] exp_mab = 16'h0;
    logic [2:0]  exp_mpc = 3'd0;
    logic        chk_en = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    pc_fetch_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MDB         (MDB),
        .mem_rdy     (mem_rdy),
        .reg_PC_in   (reg_PC_in),
        .dec_valid   (dec_valid),
        .dec_ext_cnt (dec_ext_cnt),
        .exec_done   (exec_done),
        .exec_pc_src (exec_pc_src),
        .MPC         (MPC),
        .reg_PC_out  (reg_PC_out),
        .MAB         (MAB),
        .mem_rd      (mem_rd),
        .IR          (IR),
        .ir_valid    (ir_valid),
        .ext0        (ext0),
        .ext1        (ext1)
    );

    always #5 clk = ~clk;

    // External PC source mux as it sits at the CPU top level.
    function automatic logic [15:0] src_mux(input logic [2:0] sel, input logic [15:0] pc,
                                            input logic [15:0] mdb, input logic [15:0] calc);
        case (sel)
            3'd1:    return pc + 16'd2;
            3'd2:    return calc;
            3'd3:    return {mdb[14:0], 1'b0};
            3'd4:    return mdb;
            default: return pc;
        endcase
    endfunction

    assign reg_PC_in = src_mux(MPC, reg_PC_out, MDB, calc_out);

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", reg_PC_out, m_pc);
            chk("mem_rd", {15'd0, mem_rd}, {15'd0, exp_rd});
            if (exp_mab_vld) chk("mab", MAB, exp_mab);
            chk("mpc", {13'd0, MPC}, {13'd0, exp_mpc});
            chk("ir", IR, m_ir);
            chk("ir_valid", {15'd0, ir_valid}, {15'd0, m_irv});
            chk("ext0", ext0, m_ext0);
            chk("ext1", ext1, m_ext1);
        end
    end

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        if (rst_n) m_pc = src_mux(exp_mpc, m_pc, MDB, calc_out) & 16'hFFFE;
        #1;
        mem_rdy   = 1'b0;
        dec_valid = 1'b0;
        exec_done = 1'b0;
    endtask

    task automatic set_idle();
        exp_rd = 1'b0; exp_mab_vld = 1'b0; exp_mab = 16'h0; exp_mpc = 3'd0;
    endtask

    // Read with wait states; stray strobes during waits must be ignored.
    task automatic mem_read(input logic [15:0] addr, input int waits,
                            input logic [15:0] data, input logic [2:0] mpc_rdy);
        exp_rd = 1'b1; exp_mab_vld = 1'b1; exp_mab = addr;
        for (int i = 0; i < waits; i++) begin
            exp_mpc = 3'd0; MDB = 16'hDEAD;
            dec_valid = 1'b1; exec_done = 1'b1; exec_pc_src = 2'd1;
            tick();
        end
        mem_rdy = 1'b1; MDB = data; exp_mpc = mpc_rdy;
        tick();
    endtask

    task automatic boot(input int waits, input logic [15:0] vec);
        set_idle(); exp_mab_vld = 1'b1;
        tick();
        mem_read(16'hFFFE, waits, vec, 3'd4);
    endtask

    task automatic fetch(input int waits, input logic [15:0] instr);
        mem_read(m_pc, waits, instr, 3'd1);
        m_ir = instr; m_irv = 1'b1;
    endtask

    task automatic decode(input int idle, input logic [1:0] cnt);
        set_idle();
        for (int i = 0; i < idle; i++) begin
            mem_rdy = 1'b1; MDB = 16'hBEEF; exec_done = 1'b1; exec_pc_src = 2'd2;
            tick();
        end
        dec_valid = 1'b1; dec_ext_cnt = cnt;
        tick();
        m_irv = 1'b0;
    endtask

    task automatic ext(input int waits, input logic [15:0] data, input bit second);
        mem_read(m_pc, waits, data, 3'd1);
        if (second) m_ext1 = data;
        else        m_ext0 = data;
    endtask

    task automatic exec(input int idle, input logic [1:0] src,
                        input logic [15:0] calc, input logic [15:0] mdb);
        set_idle();
        for (int i = 0; i < idle; i++) begin
            mem_rdy = 1'b1; MDB = 16'h5A5A; dec_valid = 1'b1;
            tick();
        end
        exec_done = 1'b1; exec_pc_src = src; calc_out = calc; MDB = mdb;
        case (src)
            2'd1:    exp_mpc = 3'd2;
            2'd2:    exp_mpc = 3'd4;
            2'd3:    exp_mpc = 3'd3;
            default: exp_mpc = 3'd0;
        endcase
        tick();
        set_idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_pc = 16'h0; m_ir = 16'h0; m_ext0 = 16'h0; m_ext1 = 16'h0; m_irv = 1'b0;
        set_idle(); exp_mab_vld = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        #2;
        chk_en = 1'b1;
        do_reset();

        boot(2, 16'hC001);
        chk("lit_vec_pc", reg_PC_out, 16'hC000);

        fetch(0, 16'h4031);
        decode(1, 2'd1);
        ext(1, 16'h1234, 1'b0);
        chk("lit_ir", IR, 16'h4031);
        chk("lit_ext0", ext0, 16'h1234);
        chk("lit_pc_ext", reg_PC_out, 16'hC004);

        exec(2, 2'd1, 16'hC100, 16'h0000);
        chk("lit_pc_calc", reg_PC_out, 16'hC100);

        fetch(1, 16'h1111);
        decode(0, 2'd0);
        exec(0, 2'd3, 16'h0000, 16'h2100);
        chk("lit_pc_shl", reg_PC_out, 16'h4200);

        fetch(0, 16'h2222);
        decode(0, 2'd0);
        exec(1, 2'd0, 16'h0000, 16'h0000);
        chk("lit_pc_hold", reg_PC_out, 16'h4202);

        fetch(0, 16'h3333);
        decode(0, 2'd0);
        exec(0, 2'd2, 16'h0000, 16'hFFFF);
        chk("lit_pc_odd", reg_PC_out, 16'hFFFE);

        fetch(0, 16'h4444);
        chk("lit_pc_wrap", reg_PC_out, 16'h0000);
        decode(0, 2'd3);
        ext(0, 16'hAAAA, 1'b0);
        ext(2, 16'hBBBB, 1'b1);
        exec(0, 2'd0, 16'h0000, 16'h0000);
        chk("lit_ext1", ext1, 16'hBBBB);

        fetch(0, 16'h5555);
        decode(0, 2'd2);
        ext(0, 16'h6666, 1'b0);
        exp_rd = 1'b1; exp_mab_vld = 1'b1; exp_mab = m_pc; exp_mpc = 3'd0;
        tick();
        do_reset();
        chk("lit_rst_ext0", ext0, 16'h0000);

        boot(0, 16'h8000);
        chk("lit_reboot_pc", reg_PC_out, 16'h8000);
        fetch(0, 16'h7777);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
